// File: rtl/pcs_sync_fsm_param_if.sv
// Code-group bus between the PMA deserialiser side and the PCS sync FSM.
// Define SYNC_STATS_EN to carry the saturating sync-loss counter.
interface pcs_sync_fsm_param_if #(
  parameter int LVL_W = 3
`ifdef SYNC_STATS_EN
  ,
  parameter int CNT_W = 8
`endif
);
  logic             power_on;
  logic [9:0]       PUDI;
  logic             code_sync_status;
  logic [10:0]      SUDI;
  logic [LVL_W-1:0] sync_level;
`ifdef SYNC_STATS_EN
  logic [CNT_W-1:0] sync_loss_cnt;
`endif

`ifdef SYNC_STATS_EN
  modport master (output power_on, PUDI,
                  input  code_sync_status, SUDI, sync_level, sync_loss_cnt);
  modport slave  (input  power_on, PUDI,
                  output code_sync_status, SUDI, sync_level, sync_loss_cnt);
`else
  modport master (output power_on, PUDI,
                  input  code_sync_status, SUDI, sync_level);
  modport slave  (input  power_on, PUDI,
                  output code_sync_status, SUDI, sync_level);
`endif
endinterface

// File: rtl/pcs_sync_fsm_param.sv
// Parametrised PCS code-group synchronisation FSM (comma acquisition, even/odd
// tracking, bad-level degrade/recover). Optional SYNC_STATS_EN adds a sync-loss counter.
module pcs_sync_fsm_param #(
  parameter int COMMAS_TO_SYNC  = 3,
  parameter int GOOD_TO_RECOVER = 4,
  parameter int BAD_LEVELS      = 4,
  parameter int LVL_W           = 3
`ifdef SYNC_STATS_EN
  ,
  parameter int CNT_W           = 8
`endif
) (
  input  logic Clk,
  input  logic mr_main_reset,
  pcs_sync_fsm_param_if.slave bus
);

  localparam int K_W = $clog2(COMMAS_TO_SYNC + 1);
  localparam int G_W = $clog2(GOOD_TO_RECOVER + 1);

  localparam logic [K_W-1:0]   K_LAST = K_W'(COMMAS_TO_SYNC - 1);
  localparam logic [G_W-1:0]   G_LAST = G_W'(GOOD_TO_RECOVER - 1);
  localparam logic [LVL_W-1:0] N_LAST = LVL_W'(BAD_LEVELS - 1);

  typedef enum logic [1:0] {
    ST_LOSS = 2'd0,
    ST_ACQ  = 2'd1,
    ST_SYNC = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [K_W-1:0]   k, k_n;
  logic [G_W-1:0]   good_cnt, good_cnt_n;
  logic [LVL_W-1:0] n, n_n;
  logic             rx_even, rx_even_n;
  logic [10:0]      sudi_q;

  logic comma, valid, cgbad;

  // Code-group classification uses the rx_even held from the previous group.
  assign comma = (bus.PUDI[9:3] == 7'b0011111) || (bus.PUDI[9:3] == 7'b1100000);
  assign valid = ($countones(bus.PUDI) >= 4) && ($countones(bus.PUDI) <= 6);
  assign cgbad = !valid || (comma && rx_even);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_n    = state;
    k_n        = k;
    good_cnt_n = good_cnt;
    n_n        = n;
    rx_even_n  = ~rx_even;

    unique case (state)
      ST_LOSS: begin
        if (comma) begin
          rx_even_n = 1'b1;
          if (COMMAS_TO_SYNC == 1) begin
            state_n    = ST_SYNC;
            n_n        = '0;
            good_cnt_n = '0;
          end else begin
            state_n = ST_ACQ;
            k_n     = K_W'(1);
          end
        end
      end

      ST_ACQ: begin
        if (cgbad) begin
          state_n    = ST_LOSS;
          k_n        = '0;
          good_cnt_n = '0;
        end else if (comma) begin
          rx_even_n = 1'b1;
          if (k == K_LAST) begin
            state_n    = ST_SYNC;
            k_n        = '0;
            n_n        = '0;
            good_cnt_n = '0;
          end else begin
            k_n = k + K_W'(1);
          end
        end
      end

      ST_SYNC: begin
        if (cgbad) begin
          good_cnt_n = '0;
          if (n == N_LAST) begin
            state_n = ST_LOSS;
            n_n     = '0;
            k_n     = '0;
          end else begin
            n_n = n + LVL_W'(1);
          end
        end else begin
          // A good comma here is necessarily on an even slot; realign to it.
          if (comma) rx_even_n = 1'b1;
          if (n != '0) begin
            if (good_cnt == G_LAST) begin
              n_n        = n - LVL_W'(1);
              good_cnt_n = '0;
            end else begin
              good_cnt_n = good_cnt + G_W'(1);
            end
          end else begin
            good_cnt_n = '0;
          end
        end
      end

      default: begin
        state_n    = ST_LOSS;
        k_n        = '0;
        good_cnt_n = '0;
        n_n        = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (mr_main_reset || !bus.power_on) begin
      state    <= ST_LOSS;
      k        <= '0;
      good_cnt <= '0;
      n        <= '0;
      rx_even  <= 1'b0;
      sudi_q   <= '0;
    end else begin
      state    <= state_n;
      k        <= k_n;
      good_cnt <= good_cnt_n;
      n        <= n_n;
      rx_even  <= rx_even_n;
      sudi_q   <= {rx_even_n, bus.PUDI};
    end
  end

  assign bus.code_sync_status = (state == ST_SYNC);
  assign bus.sync_level       = n;
  assign bus.SUDI             = sudi_q;

`ifdef SYNC_STATS_EN
  logic             loss_evt;
  logic [CNT_W-1:0] loss_cnt;

  // Only code-group errors count; reset and power_on drops are not link losses.
  assign loss_evt = (state == ST_SYNC) && (state_n == ST_LOSS);

  always_ff @(posedge Clk) begin
    if (mr_main_reset) begin
      loss_cnt <= '0;
    end else if (bus.power_on && loss_evt && (loss_cnt != '1)) begin
      loss_cnt <= loss_cnt + CNT_W'(1);
    end
  end

  assign bus.sync_loss_cnt = loss_cnt;
`endif

endmodule

// File: tb/tb_pcs_sync_fsm_param.sv
// Scoreboard bench for pcs_sync_fsm_param: the driver queues hand-computed
// expectations per code group, the monitor compares each registered output.
module tb_pcs_sync_fsm_param;

  localparam logic [9:0] COMMA = 10'b1100000101;
  localparam logic [9:0] D1    = 10'b0110001011;
  localparam logic [9:0] D2    = 10'b1000101011;
  localparam logic [9:0] BAD   = 10'b0000000000;

  typedef struct {
    logic        status;
    logic [10:0] sudi;
    logic [2:0]  lvl;
    logic [7:0]  cnt;
    string       name;
  } exp_t;

  logic Clk;
  logic mr_main_reset;
  exp_t sb_q[$];
  int   checks;
  int   errors;

`ifdef SYNC_STATS_EN
  pcs_sync_fsm_param_if #(.LVL_W(3), .CNT_W(8)) bus ();
  pcs_sync_fsm_param #(
    .COMMAS_TO_SYNC(3), .GOOD_TO_RECOVER(4), .BAD_LEVELS(4), .LVL_W(3), .CNT_W(8)
  ) dut (
    .Clk          (Clk),
    .mr_main_reset(mr_main_reset),
    .bus          (bus.slave)
  );
`else
  pcs_sync_fsm_param_if #(.LVL_W(3)) bus ();
  pcs_sync_fsm_param #(
    .COMMAS_TO_SYNC(3), .GOOD_TO_RECOVER(4), .BAD_LEVELS(4), .LVL_W(3)
  ) dut (
    .Clk          (Clk),
    .mr_main_reset(mr_main_reset),
    .bus          (bus.slave)
  );
`endif

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One code group: drive on the falling edge, expect the result after the next rising edge.
  task automatic v(input logic rst, input logic pwr, input logic [9:0] pudi,
                   input logic st, input logic even, input logic [2:0] lvl,
                   input logic [7:0] cnt, input string name);
    exp_t e;
    @(negedge Clk);
    mr_main_reset = rst;
    bus.power_on  = pwr;
    bus.PUDI      = pudi;
    e.status = st;
    e.sudi   = (rst || !pwr) ? 11'd0 : {even, pudi};
    e.lvl    = lvl;
    e.cnt    = cnt;
    e.name   = name;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.name, "_status"}, 32'(bus.code_sync_status), 32'(e.status));
        check({e.name, "_sudi"},   32'(bus.SUDI),             32'(e.sudi));
        check({e.name, "_level"},  32'(bus.sync_level),       32'(e.lvl));
`ifdef SYNC_STATS_EN
        check({e.name, "_lcnt"},   32'(bus.sync_loss_cnt),    32'(e.cnt));
`endif
      end
    end
  end

  initial begin : driver
    checks        = 0;
    errors        = 0;
    mr_main_reset = 1'b1;
    bus.power_on  = 1'b1;
    bus.PUDI      = D1;

    // 1: reset then acquire on three even commas
    v(1, 1, D1,    0, 0, 0, 0, "t1_rst");
    v(0, 1, COMMA, 0, 1, 0, 0, "t1_c1");
    v(0, 1, D1,    0, 0, 0, 0, "t1_d1");
    v(0, 1, COMMA, 0, 1, 0, 0, "t1_c2");
    v(0, 1, D2,    0, 0, 0, 0, "t1_d2");
    v(0, 1, COMMA, 1, 1, 0, 0, "t1_c3");
    // 2: one bad group, recover after four good
    v(0, 1, BAD,   1, 0, 1, 0, "t2_bad");
    v(0, 1, D1,    1, 1, 1, 0, "t2_g1");
    v(0, 1, D2,    1, 0, 1, 0, "t2_g2");
    v(0, 1, D1,    1, 1, 1, 0, "t2_g3");
    v(0, 1, D2,    1, 0, 0, 0, "t2_g4");
    // 3: four bad groups lose sync
    v(0, 1, BAD,   1, 1, 1, 0, "t3_b1");
    v(0, 1, BAD,   1, 0, 2, 0, "t3_b2");
    v(0, 1, BAD,   1, 1, 3, 0, "t3_b3");
    v(0, 1, BAD,   0, 0, 0, 1, "t3_b4");
    // 4: comma on an odd slot during acquisition falls back to LOSS
    v(0, 1, COMMA, 0, 1, 0, 1, "t4_c1");
    v(0, 1, D1,    0, 0, 0, 1, "t4_d1");
    v(0, 1, COMMA, 0, 1, 0, 1, "t4_c2");
    v(0, 1, COMMA, 0, 0, 0, 1, "t4_c3");
    // 5: resync, build partial state, reset with valid data
    v(0, 1, COMMA, 0, 1, 0, 1, "t5_c1");
    v(0, 1, D1,    0, 0, 0, 1, "t5_d1");
    v(0, 1, COMMA, 0, 1, 0, 1, "t5_c2");
    v(0, 1, D2,    0, 0, 0, 1, "t5_d2");
    v(0, 1, COMMA, 1, 1, 0, 1, "t5_c3");
    v(0, 1, BAD,   1, 0, 1, 1, "t5_bad");
    v(0, 1, D1,    1, 1, 1, 1, "t5_g1");
    v(1, 1, D2,    0, 0, 0, 0, "t5_rst");
    v(0, 1, D1,    0, 1, 0, 0, "t5_post");
    // 6: power_on drop mid-acquisition clears partial comma count
    v(0, 1, COMMA, 0, 1, 0, 0, "t6_c1");
    v(0, 1, D1,    0, 0, 0, 0, "t6_d1");
    v(0, 0, COMMA, 0, 0, 0, 0, "t6_off_c");
    v(0, 0, D2,    0, 0, 0, 0, "t6_off_d");
    v(0, 0, COMMA, 0, 0, 0, 0, "t6_off_c2");
    v(0, 1, COMMA, 0, 1, 0, 0, "t6_r_c1");
    v(0, 1, D1,    0, 0, 0, 0, "t6_r_d1");
    v(0, 1, COMMA, 0, 1, 0, 0, "t6_r_c2");
    v(0, 1, D2,    0, 0, 0, 0, "t6_r_d2");
    v(0, 1, COMMA, 1, 1, 0, 0, "t6_r_c3");
    v(0, 0, D1,    0, 0, 0, 0, "t6_pwr_drop");
    v(0, 1, D1,    0, 1, 0, 0, "t6_pwr_back");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge Clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
